alu_seq: RTL

Parametrised, registered successor to the combinational accumulator/B-register adder. Executes add, subtract, bitwise logic, single-bit shifts and a multi-cycle shift-add multiply on WIDTH-bit operands. Holds the result and status flags in registers. Drives the shared tristate data bus on command. It sits between the accumulator and B register and the system bus. The controller sequences it with a start/busy/done handshake.

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU between accumulator/B register and the system bus.
// Single-cycle add/sub/logic/shift plus a WIDTH-step shift-add unsigned multiply.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] reb,
    input  logic             eu,
    output tri   [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    // state | meaning
    // S_IDLE | waiting for start; single-cycle ops complete here
    // S_MUL  | shift-add multiply iterating, cnt steps remaining
    typedef enum logic {S_IDLE, S_MUL} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     mul_add;
    logic [CW-1:0]      cnt;

    logic               ld_alu, ld_mul, mul_step, mul_last;

    logic               sub;
    logic [WIDTH-1:0]   b_op;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   low_sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;

    // Two's-complement adder; the carry into the MSB comes from a separate low-part sum.
    assign sub     = (op == OP_SUB);
    assign b_op    = sub ? ~reb : reb;
    assign sum     = {1'b0, acc} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    assign low_sum = {1'b0, acc[WIDTH-2:0]} + {1'b0, b_op[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, sub};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = low_sum[WIDTH-1] ^ sum[WIDTH];
            end
            OP_AND: alu_res = acc & reb;
            OP_OR:  alu_res = acc | reb;
            OP_XOR: alu_res = acc ^ reb;
            OP_SHL: begin
                alu_res = {acc[WIDTH-2:0], 1'b0};
                alu_c   = acc[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, acc[WIDTH-1:1]};
                alu_c   = acc[0];
            end
            default: ;
        endcase
    end

    // Multiplier sits in the low half of prod and is consumed one bit per step.
    assign mul_add  = prod[0] ? ({1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                              : {1'b0, prod[2*WIDTH-1:WIDTH]};
    assign prod_nxt = {mul_add, prod[WIDTH-1:1]};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_alu    = 1'b0;
        ld_mul    = 1'b0;
        mul_step  = 1'b0;
        mul_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        ld_mul    = 1'b1;
                        state_nxt = S_MUL;
                    end else begin
                        ld_alu = 1'b1;
                    end
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                if (cnt == CW'(1)) begin
                    mul_last  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            result <= '0;
            hi     <= '0;
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ld_alu) begin
                result <= alu_res;
                flag_c <= alu_c;
                flag_v <= alu_v;
                flag_z <= (alu_res == '0);
                flag_n <= alu_res[WIDTH-1];
                done   <= 1'b1;
            end
            if (ld_mul) begin
                mcand <= acc;
                prod  <= {{WIDTH{1'b0}}, reb};
                cnt   <= CW'(WIDTH);
            end
            if (mul_step) begin
                prod <= prod_nxt;
                cnt  <= cnt - 1'b1;
            end
            if (mul_last) begin
                result <= prod_nxt[WIDTH-1:0];
                hi     <= prod_nxt[2*WIDTH-1:WIDTH];
                flag_c <= (prod_nxt[2*WIDTH-1:WIDTH] != '0);
                flag_v <= 1'b0;
                flag_z <= (prod_nxt[WIDTH-1:0] == '0);
                flag_n <= prod_nxt[WIDTH-1];
                done   <= 1'b1;
            end
        end
    end

    assign busy = (state == S_MUL);
    assign bus  = eu ? result : {WIDTH{1'bz}};

endmodule
